// File: rtl/ysyx_24110006_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_24110006_ifu_pkg;

    // Fetch sequencer: REQ presents a request, WAIT holds until the response is taken.
    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

    // One fetched instruction as handed to decode.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exception;
        logic [3:0]  mcause;
    } fetch_pkt_t;

    // Sequential successor; 32-bit modulo, so the top of the address space wraps to 0.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc, input logic [31:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/ysyx_24110006_ifu_skid.sv
// Two-entry valid/ready buffer between the IFU and decode.
// Registered outputs; a synchronous clear drops both entries in one cycle.
module ysyx_24110006_ifu_skid
    import ysyx_24110006_ifu_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  fetch_pkt_t in_pkt_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output fetch_pkt_t out_pkt_o
);

    fetch_pkt_t mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic       push;
    logic       pop;

    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_pkt_o   = mem_q[rd_ptr_q];
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // Circular two-slot storage; clear wins over any push/pop in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (clr_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_pkt_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/ysyx_24110006_ifu.sv
// Instruction fetch unit: generates the fetch PC, keeps one request in flight,
// forwards the I-cache response to decode and applies execute redirects.
// Optional feature macro: IFU_SKID_EN (registered 2-entry buffer toward decode).
module ysyx_24110006_ifu
    import ysyx_24110006_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    // request to I-cache
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic [31:0] o_req_pc,
    output logic        o_req_fencei,
    output logic        o_flush,
    // response from I-cache
    input  logic        i_rsp_valid,
    output logic        o_rsp_ready,
    input  logic [31:0] i_rsp_inst,
    input  logic [31:0] i_rsp_pc,
    input  logic        i_rsp_exception,
    input  logic [3:0]  i_rsp_mcause,
    // toward decode
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_exception,
    output logic [3:0]  o_mcause,
    // redirect from execute/commit
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_redirect_fencei
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        fencei_q, fencei_d;

    logic        req_hs;
    logic        rsp_hs;
    logic        fwd;
    logic        flush;
    fetch_pkt_t  rsp_pkt;

    assign rsp_pkt = '{inst: i_rsp_inst, pc: i_rsp_pc, exception: i_rsp_exception, mcause: i_rsp_mcause};

    // Request side. Gating with reset keeps the cache port quiet while reset is held
    // and lets the first request go out in the very first cycle after release.
    assign o_req_valid  = (state_q == REQ) && i_reset_n;
    assign o_req_pc     = pc_q;
    assign o_req_fencei = fencei_q && o_req_valid;
    assign req_hs       = o_req_valid && i_req_ready;

    // A response is live unless it belongs to a redirected-away fetch or a redirect
    // arrives with it; stale responses are always accepted so the cache drains.
    assign fwd    = i_rsp_valid && !drop_q && !i_redirect;
    assign rsp_hs = i_rsp_valid && o_rsp_ready;

    // Flush whenever the redirect leaves a fetch inside the cache: in REQ a request may
    // be accepted this very cycle, in WAIT unless the response is consumed right now.
    assign flush   = i_redirect && ((state_q == REQ) || !rsp_hs);
    assign o_flush = flush;

`ifdef IFU_SKID_EN
    logic       skid_in_ready;
    fetch_pkt_t skid_out_pkt;

    assign o_rsp_ready = skid_in_ready || drop_q || i_redirect;

    ysyx_24110006_ifu_skid u_skid (
        .clk_i       (i_clock),
        .rst_ni      (i_reset_n),
        .clr_i       (i_redirect),
        .in_valid_i  (fwd),
        .in_ready_o  (skid_in_ready),
        .in_pkt_i    (rsp_pkt),
        .out_valid_o (o_valid),
        .out_ready_i (i_ready),
        .out_pkt_o   (skid_out_pkt)
    );

    assign o_inst      = skid_out_pkt.inst;
    assign o_pc        = skid_out_pkt.pc;
    assign o_exception = skid_out_pkt.exception;
    assign o_mcause    = skid_out_pkt.mcause;
`else
    // Pass-through: decode back-pressure reaches the cache directly.
    assign o_rsp_ready = i_ready || drop_q || i_redirect;
    assign o_valid     = fwd;
    assign o_inst      = rsp_pkt.inst;
    assign o_pc        = rsp_pkt.pc;
    assign o_exception = rsp_pkt.exception;
    assign o_mcause    = rsp_pkt.mcause;
`endif

    // Next-state: redirect overrides every other event of the cycle.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        drop_d   = drop_q;
        fencei_d = fencei_q;

        if (req_hs) begin
            fencei_d = 1'b0;
        end

        if (i_redirect) begin
            state_d = REQ;
            pc_d    = i_redirect_pc;
            // A stale fetch left in flight must be discarded when it returns;
            // one consumed this cycle no longer needs a drop.
            drop_d  = flush || (drop_q && !rsp_hs);
            if (i_redirect_fencei) begin
                fencei_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                REQ: begin
                    if (req_hs) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (rsp_hs) begin
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase

            if (rsp_hs) begin
                if (drop_q) begin
                    // Stale response swallowed; pc_q already holds the redirect target.
                    drop_d = 1'b0;
                end else begin
                    // Faulting fetches advance too; the trap redirect fixes the PC.
                    pc_d = next_seq_pc(i_rsp_pc, PC_STEP);
                end
            end
        end
    end

    // Fetch sequencer state registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            fencei_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            drop_q   <= drop_d;
            fencei_q <= fencei_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24110006_ifu.sv
// Self-checking bench for ysyx_24110006_ifu (default pass-through build).
// The bench plays the I-cache (2-cycle hit, one request at a time) and keeps a
// fetch-epoch model: every redirect opens a new epoch, and only responses to
// requests issued in the current epoch may reach decode.
module tb_ysyx_24110006_ifu;

    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        o_req_valid, o_req_fencei, o_flush, o_rsp_ready;
    logic        o_valid, o_exception;
    logic [31:0] o_req_pc, o_inst, o_pc;
    logic [3:0]  o_mcause;
    logic        i_req_ready = 1'b1;
    logic        i_rsp_valid = 1'b0;
    logic [31:0] i_rsp_inst = '0;
    logic [31:0] i_rsp_pc = '0;
    logic        i_rsp_exception = 1'b0;
    logic [3:0]  i_rsp_mcause = '0;
    logic        i_ready = 1'b1;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        i_redirect_fencei = 1'b0;

    always #5 clk = ~clk;

    ysyx_24110006_ifu dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .o_req_valid      (o_req_valid),
        .i_req_ready      (i_req_ready),
        .o_req_pc         (o_req_pc),
        .o_req_fencei     (o_req_fencei),
        .o_flush          (o_flush),
        .i_rsp_valid      (i_rsp_valid),
        .o_rsp_ready      (o_rsp_ready),
        .i_rsp_inst       (i_rsp_inst),
        .i_rsp_pc         (i_rsp_pc),
        .i_rsp_exception  (i_rsp_exception),
        .i_rsp_mcause     (i_rsp_mcause),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_inst           (o_inst),
        .o_pc             (o_pc),
        .o_exception      (o_exception),
        .o_mcause         (o_mcause),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .i_redirect_fencei(i_redirect_fencei)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]} ^ 32'h0000_0013;
    endfunction

    // model / cache state
    logic        pend = 1'b0;
    int          dly = 0;
    logic [31:0] ppc = '0;
    int          ptag = 0;
    int          epoch = 0;
    logic [31:0] next_pc = RST_PC;
    logic        fence_pend = 1'b0;
    logic        inj_exc = 1'b0;

    logic [31:0] req_pc_q[$];
    logic        req_fi_q[$];
    logic [31:0] dlv_pc_q[$];
    logic        dlv_exc_q[$];
    logic [3:0]  dlv_mc_q[$];

    logic        m_req_hs, m_rsp_hs, m_live;
    logic [31:0] m_req_pc;
    int          m_old_ep;

    // Cache behaviour and model update, from the values seen at the edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            pend       = 1'b0;
            next_pc    = RST_PC;
            fence_pend = 1'b0;
            epoch      = epoch + 1;
            #1;
            i_rsp_valid = 1'b0;
            i_req_ready = 1'b1;
        end else begin
            m_req_hs = o_req_valid && i_req_ready;
            m_rsp_hs = i_rsp_valid && o_rsp_ready;
            m_live   = pend && (ptag == epoch) && !i_redirect;
            m_req_pc = o_req_pc;
            m_old_ep = epoch;
            if (m_req_hs) begin
                req_pc_q.push_back(o_req_pc);
                req_fi_q.push_back(o_req_fencei);
            end
            if (o_valid && i_ready) begin
                dlv_pc_q.push_back(o_pc);
                dlv_exc_q.push_back(o_exception);
                dlv_mc_q.push_back(o_mcause);
            end
            if (m_rsp_hs && m_live) next_pc = i_rsp_pc + 32'd4;
            if (m_req_hs) fence_pend = 1'b0;
            if (i_redirect) begin
                epoch   = epoch + 1;
                next_pc = i_redirect_pc;
                if (i_redirect_fencei) fence_pend = 1'b1;
            end
            #1;
            if (m_rsp_hs) begin
                i_rsp_valid = 1'b0;
                pend        = 1'b0;
            end
            if (m_req_hs) begin
                pend = 1'b1;
                dly  = 1;
                ppc  = m_req_pc;
                ptag = m_old_ep;
            end else if (pend && !i_rsp_valid) begin
                dly = dly - 1;
                if (dly == 0) begin
                    i_rsp_valid     = 1'b1;
                    i_rsp_pc        = ppc;
                    i_rsp_inst      = inst_of(ppc);
                    i_rsp_exception = inj_exc;
                    i_rsp_mcause    = inj_exc ? 4'd1 : 4'd0;
                    inj_exc         = 1'b0;
                end
            end
            i_req_ready = !pend;
        end
    end

    // Per-cycle compare against the epoch model.
    always @(negedge clk) begin
        if (rst_n) begin
            automatic logic live_rsp = i_rsp_valid && (ptag == epoch) && !i_redirect;
            automatic logic exp_req  = !(pend && (ptag == epoch));
            chk("o_valid", o_valid, live_rsp);
            if (live_rsp) begin
                chk("o_pc", o_pc, i_rsp_pc);
                chk("o_inst", o_inst, inst_of(i_rsp_pc));
                chk("o_exception", o_exception, i_rsp_exception);
                chk("o_mcause", o_mcause, i_rsp_mcause);
            end
            if (i_rsp_valid) chk("o_rsp_ready", o_rsp_ready, live_rsp ? i_ready : 1'b1);
            chk("o_flush", o_flush, i_redirect && !i_rsp_valid);
            chk("o_req_valid", o_req_valid, exp_req);
            if (exp_req) begin
                chk("o_req_pc", o_req_pc, next_pc);
                chk("o_req_fencei", o_req_fencei, fence_pend);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_reqs(input int n);
        for (int k = 0; k < 200 && req_pc_q.size() < n; k++) tick();
        chk("req_timeout", req_pc_q.size() >= n, 1'b1);
    endtask

    task automatic wait_dlv(input int n);
        for (int k = 0; k < 200 && dlv_pc_q.size() < n; k++) tick();
        chk("dlv_timeout", dlv_pc_q.size() >= n, 1'b1);
    endtask

    // Outstanding live fetch, response not back yet.
    task automatic wait_wait();
        for (int k = 0; k < 200 && !(pend && !i_rsp_valid && ptag == epoch); k++) tick();
        chk("wait_timeout", pend && !i_rsp_valid, 1'b1);
    endtask

    task automatic wait_rsp();
        for (int k = 0; k < 200 && !(i_rsp_valid && ptag == epoch); k++) tick();
        chk("rsp_timeout", i_rsp_valid, 1'b1);
    endtask

    task automatic redirect(input logic [31:0] tgt, input logic fi);
        i_redirect        = 1'b1;
        i_redirect_pc     = tgt;
        i_redirect_fencei = fi;
        tick();
        i_redirect        = 1'b0;
        i_redirect_fencei = 1'b0;
    endtask

    initial begin
        int n, d;
        logic [31:0] held;
        repeat (3) tick();
        #1;
        chk("rst_req_valid", o_req_valid, 1'b0);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_flush", o_flush, 1'b0);
        chk("rst_req_fencei", o_req_fencei, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("first_req_valid", o_req_valid, 1'b1);
        chk("first_req_pc", o_req_pc, 32'h3000_0000);

        // sequential fetch
        wait_dlv(3);
        chk("seq_req0", req_pc_q[0], 32'h3000_0000);
        chk("seq_req1", req_pc_q[1], 32'h3000_0004);
        chk("seq_req2", req_pc_q[2], 32'h3000_0008);
        chk("seq_dlv0", dlv_pc_q[0], 32'h3000_0000);
        chk("seq_dlv1", dlv_pc_q[1], 32'h3000_0004);
        chk("seq_dlv2", dlv_pc_q[2], 32'h3000_0008);

        // decode back-pressure for 5 cycles
        wait_rsp();
        held    = i_rsp_pc;
        n       = req_pc_q.size();
        i_ready = 1'b0;
        repeat (5) tick();
        #1;
        chk("bp_held_pc", held, 32'h3000_000C);
        chk("bp_valid", o_valid, 1'b1);
        chk("bp_pc", o_pc, held);
        chk("bp_no_req", req_pc_q.size(), n);
        i_ready = 1'b1;

        // redirect while waiting: flush pulse, stale dropped
        wait_wait();
        n = req_pc_q.size();
        d = dlv_pc_q.size();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h3000_0100;
        #3 chk("wait_flush", o_flush, 1'b1);
        tick();
        i_redirect = 1'b0;
        #1 chk("wait_flush_end", o_flush, 1'b0);
        wait_reqs(n + 1);
        chk("wait_redir_req", req_pc_q[n], 32'h3000_0100);
        wait_dlv(d + 1);
        chk("wait_redir_dlv", dlv_pc_q[d], 32'h3000_0100);

        // redirect coinciding with the response
        wait_rsp();
        n = req_pc_q.size();
        d = dlv_pc_q.size();
        redirect(32'h3000_0180, 1'b0);
        wait_dlv(d + 1);
        chk("same_dlv", dlv_pc_q[d], 32'h3000_0180);
        chk("same_req", req_pc_q[n], 32'h3000_0180);
        chk("same_no_refetch", req_pc_q.size(), n + 1);

        // fence.i redirect
        wait_wait();
        n = req_pc_q.size();
        redirect(32'h3000_0040, 1'b1);
        wait_reqs(n + 2);
        chk("fi_req_pc", req_pc_q[n], 32'h3000_0040);
        chk("fi_req_fencei", req_fi_q[n], 1'b1);
        chk("fi_next_pc", req_pc_q[n + 1], 32'h3000_0044);
        chk("fi_next_fencei", req_fi_q[n + 1], 1'b0);

        // faulting fetch
        wait_dlv(dlv_pc_q.size() + 1);
        inj_exc = 1'b1;
        d = dlv_pc_q.size();
        wait_dlv(d + 1);
        chk("exc_pc", dlv_pc_q[d], 32'h3000_0048);
        chk("exc_flag", dlv_exc_q[d], 1'b1);
        chk("exc_mcause", dlv_mc_q[d], 4'd1);
        n = req_pc_q.size();
        wait_reqs(n + 1);
        chk("exc_advance", req_pc_q[n], 32'h3000_004C);
        wait_wait();
        n = req_pc_q.size();
        redirect(32'h3000_0200, 1'b0);
        wait_reqs(n + 1);
        chk("trap_req", req_pc_q[n], 32'h3000_0200);

        // 32-bit wrap
        wait_wait();
        n = req_pc_q.size();
        redirect(32'hFFFF_FFFC, 1'b0);
        wait_reqs(n + 2);
        chk("wrap_top", req_pc_q[n], 32'hFFFF_FFFC);
        chk("wrap_zero", req_pc_q[n + 1], 32'h0000_0000);

        // reset while waiting
        wait_wait();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", o_req_valid, 1'b0);
        chk("mid_rst_valid", o_valid, 1'b0);
        chk("mid_rst_flush", o_flush, 1'b0);
        chk("mid_rst_fencei", o_req_fencei, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        n = req_pc_q.size();
        wait_reqs(n + 1);
        chk("post_rst_req", req_pc_q[n], RST_PC);

        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
